leb128_decoder: RTL

- Byte-serial LEB128 immediate decoder in the fetch/decode path, directly upstream of the cpu execute stage.
- Consumes the instruction byte stream following an i32.const/i64.const opcode (or any other LEB128 immediate) and produces one full-width value per encoded number.
- The cpu pushes this value onto its result stack.
- Signed and unsigned decoding are selected by parameter; malformed encodings raise a sticky error that the cpu maps to a trap.

---
 rtl/leb128_decoder_if.sv | 24 ++
 rtl/leb128_decoder.sv | 97 +++++++++
 2 files changed

// File: rtl/leb128_decoder_if.sv
// Handshake bundle for the LEB128 immediate decoder: byte stream in, decoded value out.
// The master side feeds bytes and consumes values; the slave side is the decoder.
interface leb128_decoder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_len;
  logic             out_ready;
  logic             error;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_len, error
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_len, error
  );
endinterface

// File: rtl/leb128_decoder.sv
// Byte-serial sLEB128/uLEB128 decoder feeding the execute stage; one value per encoded number.
// Optional overlong-final-byte check enabled by defining LEB128_OVERLONG_CHECK_EN.
module leb128_decoder #(
  parameter int WIDTH  = 64,
  parameter bit SIGNED = 1'b1
) (
  input logic             clk,
  input logic             reset,
  leb128_decoder_if.slave bus
);
  localparam int         MAX_BYTES = (WIDTH + 6) / 7;
  localparam logic [3:0] LAST      = 4'(MAX_BYTES - 1);

  typedef enum logic [1:0] {ACCUM, DONE, ERROR} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       n_q, n_d;
  logic [3:0]       len_q, len_d;

  logic [6:0]       sh;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] fill;
  logic             overlong;

  // Payload bits landing at or beyond WIDTH fall off the shift, which is the truncation we want.
  assign sh     = {3'b000, n_q} * 7'd7;
  assign acc_nx = acc_q | (WIDTH'(bus.in_data[6:0]) << sh);
  assign fill   = (SIGNED && bus.in_data[6]) ? ({WIDTH{1'b1}} << (sh + 7'd7)) : '0;

`ifdef LEB128_OVERLONG_CHECK_EN
  // Only U payload bits of the last permitted byte fit; the rest must be pure extension.
  localparam int U = WIDTH - 7 * (MAX_BYTES - 1);
  assign overlong = (n_q == LAST) &&
                    (SIGNED ? (bus.in_data[6:U] != {(7-U){bus.in_data[U-1]}})
                            : (bus.in_data[6:U] != '0));
`else
  assign overlong = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      data_q  <= '0;
      n_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      n_q     <= n_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    data_d  = data_q;
    n_d     = n_q;
    len_d   = len_q;
    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d = acc_nx;
          n_d   = n_q + 4'd1;
          if (bus.in_data[7]) begin
            if (n_q == LAST) state_d = ERROR;
          end else if (overlong) begin
            state_d = ERROR;
          end else begin
            state_d = DONE;
            data_d  = acc_nx | fill;
            len_d   = n_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          n_d     = '0;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = ACCUM;
    endcase
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.error     = (state_q == ERROR);
  assign bus.out_data  = data_q;
  assign bus.out_len   = len_q;
endmodule
